mod_mul_frontend: RTL

MOD_MUL_FRONTEND -- requirements
Module: mod_mul_frontend

---
 rtl/mod_mul_frontend.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mod_mul_frontend.sv
// Front end of a modular multiplier: latches an operand pair, forms a*b with a
// radix-2 shift-add loop, then hands the product to a Barrett reducer.
module mod_mul_frontend #(
  parameter int Q_WIDTH    = 23,
  parameter int DATA_WIDTH = 48
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [Q_WIDTH-1:0]    a,
  input  logic [Q_WIDTH-1:0]    b,
  input  logic [Q_WIDTH-1:0]    Q,
  output logic                  red_start,
  output logic [DATA_WIDTH-1:0] red_data,
  input  logic                  red_done,
  output logic                  busy,
  output logic                  range_err
);

  localparam int ACC_W = 2 * Q_WIDTH;
  localparam int CNT_W = $clog2(Q_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(Q_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    ISSUE,
    WAIT
  } state_t;

  state_t                state_q, state_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [ACC_W-1:0]      mcand_q, mcand_d;
  logic [Q_WIDTH-1:0]    mplier_q, mplier_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  red_start_q, red_start_d;
  logic [DATA_WIDTH-1:0] red_data_q, red_data_d;
  logic                  busy_q, busy_d;
  logic                  range_err_q, range_err_d;

  assign in_ready  = (state_q == IDLE);
  assign red_start = red_start_q;
  assign red_data  = red_data_q;
  assign busy      = busy_q;
  assign range_err = range_err_q;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    cnt_d       = cnt_q;
    red_start_d = 1'b0;
    red_data_d  = red_data_q;
    range_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // The modulus only feeds this check, so it is consumed here rather than stored.
          range_err_d = (a >= Q) || (b >= Q);
          mcand_d     = ACC_W'(a);
          mplier_d    = b;
          acc_d       = '0;
          cnt_d       = '0;
          state_d     = MULT;
        end
      end
      MULT: begin
        // Multiplicand shifts left while the multiplier shifts right, so bit i
        // of b always lines up with a << i without a variable shifter.
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        red_start_d = 1'b1;
        red_data_d  = DATA_WIDTH'(acc_q);
        state_d     = WAIT;
      end
      WAIT: begin
        if (red_done) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      red_start_q <= 1'b0;
      red_data_q  <= '0;
      busy_q      <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
      red_start_q <= red_start_d;
      red_data_q  <= red_data_d;
      busy_q      <= busy_d;
      range_err_q <= range_err_d;
    end
  end

endmodule
